puck_motion: RTL and testbench
==============================

# puck_motion

Parametrised puck motion and collision engine for the air-hockey playfield. On every frame step it advances the puck by a fixed speed, reflects it off the top and bottom walls, the side walls and both paddles, and detects goals. It owns a serve/score state machine and sits between the frame-tick generator and the puck renderer. It supersedes the fixed-size wall-only direction tracker with registered position, paddle hits and goal handling.

## Interface
- FIELD_W, 160: playfield width in pixels.
- FIELD_H, 120: playfield height in pixels.
- PUCK, 4: puck edge length; (x,y) is the puck's top-left pixel.
- SPEED, 1: pixels moved per axis per step; must satisfy 1 ≤ SPEED < PUCK.
- PADDLE_H, 16: paddle height.
- PADDLE_XL, 8: column of the left paddle's right face.
- PADDLE_XR, 148: column of the right paddle's left face.
- GOAL_LO, 40 / GOAL_HI, 80: goal mouth row span, inclusive / exclusive.
- HOLD, 60: steps held in SCORED.
- X_W, 8 / Y_W, 7: coordinate widths.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- step  in  1  frame tick, one-cycle pulse.
- serve  in  1  launch request.
- pad_l_y, pad_r_y  in  Y_W  paddle top rows.
- x  out  X_W  puck column.
- y  out  Y_W  puck row.
- dir_x  out  1  1 = +x.
- dir_y  out  1  1 = +y.
- bounce  out  1  one-cycle pulse on any reflection.
- goal_l, goal_r  out  1  one-cycle pulse when the puck enters the left or right goal.
- state  out  2  IDLE=0, PLAY=1, SCORED=2.

## Operation
- Reset (reset_n low at a clock edge): x=(FIELD_W-PUCK)/2, y=(FIELD_H-PUCK)/2, dir_x=1, dir_y=1, state=IDLE, all pulses 0. Reset overrides every other input in any state.
- IDLE: the puck is frozen and step is ignored. When serve=1, the block enters PLAY on the next edge. If serve and step are both high, the serve is taken and there is no movement that cycle.
- PLAY, on step: each axis computes its candidate position as pos ± SPEED. Arithmetic uses X_W+1 / Y_W+1 bits, so there is no wrap-around.
- Y walls:
  - Candidate ≥ FIELD_H-PUCK → clamp to FIELD_H-PUCK and set dir_y=0.
  - Moving up with y ≤ SPEED → clamp to 0 and set dir_y=1.
- Paddles are checked before the x walls. A paddle hit requires the puck rows [y, y+PUCK) to overlap [pad_y, pad_y+PADDLE_H), evaluated on the current y.
  - Right paddle: dir_x=1, x+PUCK ≤ PADDLE_XR, and candidate+PUCK > PADDLE_XR → x=PADDLE_XR-PUCK, dir_x=0.
  - Left paddle: dir_x=0, x ≥ PADDLE_XL, and candidate < PADDLE_XL → x=PADDLE_XL, dir_x=1.
- X walls behave like the Y walls, using FIELD_W, unless a goal fires.
- Any axis reflection asserts bounce for one cycle. A corner hit flips both directions and produces a single bounce pulse.
- SCORED:
  - Counts step pulses. The puck is frozen at the wall and pulses stay low.
  - On the HOLD-th step: state=IDLE, puck recentred, dir_y=1. dir_x points away from the goal just scored (1 after goal_l, 0 after goal_r).
  - serve is ignored.

## Timing
- All outputs are registered. Position, direction and pulses update on the edge where step is sampled high, so they are visible in the following cycle.
- Pulses last exactly one cycle.
- Throughput is one step per cycle. Back-to-back steps are legal.
- The SCORED→IDLE transition happens on the same edge that samples the HOLD-th step.

## Configuration
- PUCK_GOALS_EN defined: the goal logic is compiled in.
  - Goal condition: an x-wall hit with y ≥ GOAL_LO and y+PUCK ≤ GOAL_HI.
  - On a goal: clamp x to the wall, assert goal_l (left wall) or goal_r (right wall) instead of bounce, leave dir_x unchanged, and enter SCORED.
- PUCK_GOALS_EN undefined: every x-wall contact reflects, SCORED is unreachable, and goal_l and goal_r are tied to 0.

## Test plan
- Reset, then serve, then 3 steps with no paddle overlap → x=78,79,80,81 and y=58,59,60,61, with no pulses.
- Start at y=115, dir_y=1, step → y=116, dir_y=0, bounce=1 for one cycle. Next step → y=115.
- pad_r_y=50, puck at x=144, y=52, dir_x=1, step → x=144, dir_x=0, bounce=1. Repeat with pad_r_y=0 → x=145, no bounce.
- With PUCK_GOALS_EN: puck at x=1, y=50, dir_x=0, step → x=0, goal_l=1, state=SCORED. After 60 steps → state=IDLE, x=78, y=58, dir_x=1.
- Corner case: puck at x=156, y=116 with pads away and the macro undefined, step → both directions flip and bounce is a single pulse.
- reset_n low mid-PLAY and mid-SCORED → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/puck_motion.sv
// puck_motion -- puck position, wall/paddle reflection, goal detection and
// serve/score sequencing for the air-hockey playfield.
//
// Optional feature: define PUCK_GOALS_EN to compile in goal detection.
// Without it every side-wall contact reflects and goal_l/goal_r stay low.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | puck frozen at centre, waiting for serve
// PLAY   | puck advances SPEED pixels per axis on every step
// SCORED | puck frozen at the goal wall, counting HOLD steps before IDLE
module puck_motion #(
    parameter int FIELD_W   = 160,
    parameter int FIELD_H   = 120,
    parameter int PUCK      = 4,
    parameter int SPEED     = 1,
    parameter int PADDLE_H  = 16,
    parameter int PADDLE_XL = 8,
    parameter int PADDLE_XR = 148,
    parameter int GOAL_LO   = 40,
    parameter int GOAL_HI   = 80,
    parameter int HOLD      = 60,
    parameter int X_W       = 8,
    parameter int Y_W       = 7
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           step,
    input  logic           serve,
    input  logic [Y_W-1:0] pad_l_y,
    input  logic [Y_W-1:0] pad_r_y,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           dir_x,
    output logic           dir_y,
    output logic           bounce,
    output logic           goal_l,
    output logic           goal_r,
    output logic [1:0]     state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SCORED = 2'd2
    } state_t;

`ifdef PUCK_GOALS_EN
    localparam logic GOALS_ON = 1'b1;
`else
    localparam logic GOALS_ON = 1'b0;
`endif

    // Widened constants: comparisons run one bit wider than the coordinate
    // so pos + SPEED + PUCK never wraps.
    localparam logic [X_W:0]   X_MAX      = (X_W+1)'(FIELD_W - PUCK);
    localparam logic [X_W:0]   X_SPD      = (X_W+1)'(SPEED);
    localparam logic [X_W:0]   X_PUCK     = (X_W+1)'(PUCK);
    localparam logic [X_W:0]   X_PADL     = (X_W+1)'(PADDLE_XL);
    localparam logic [X_W:0]   X_PADR     = (X_W+1)'(PADDLE_XR);
    localparam logic [X_W-1:0] X_MAX_N    = X_W'(FIELD_W - PUCK);
    localparam logic [X_W-1:0] X_SPD_N    = X_W'(SPEED);
    localparam logic [X_W-1:0] X_PADL_N   = X_W'(PADDLE_XL);
    localparam logic [X_W-1:0] X_PADR_HIT = X_W'(PADDLE_XR - PUCK);
    localparam logic [X_W-1:0] X_CTR      = X_W'((FIELD_W - PUCK) / 2);

    localparam logic [Y_W:0]   Y_MAX      = (Y_W+1)'(FIELD_H - PUCK);
    localparam logic [Y_W:0]   Y_SPD      = (Y_W+1)'(SPEED);
    localparam logic [Y_W:0]   Y_PUCK     = (Y_W+1)'(PUCK);
    localparam logic [Y_W:0]   Y_PADH     = (Y_W+1)'(PADDLE_H);
    localparam logic [Y_W:0]   Y_GLO      = (Y_W+1)'(GOAL_LO);
    localparam logic [Y_W:0]   Y_GHI      = (Y_W+1)'(GOAL_HI);
    localparam logic [Y_W-1:0] Y_MAX_N    = Y_W'(FIELD_H - PUCK);
    localparam logic [Y_W-1:0] Y_SPD_N    = Y_W'(SPEED);
    localparam logic [Y_W-1:0] Y_CTR      = Y_W'((FIELD_H - PUCK) / 2);

    localparam int             HOLD_W     = $clog2(HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

    state_t            state_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic              dir_x_q;
    logic              dir_y_q;
    logic              bounce_q;
    logic              goal_l_q;
    logic              goal_r_q;
    logic [HOLD_W-1:0] hold_q;

    logic [X_W-1:0]    x_d;
    logic [Y_W-1:0]    y_d;
    logic              dir_x_d;
    logic              dir_y_d;
    logic              x_refl;
    logic              x_wall;
    logic              y_refl;
    logic              goal_hit;

    logic [X_W:0]      x_ext;
    logic [X_W:0]      x_inc;
    logic [X_W-1:0]    x_dec;
    logic [Y_W:0]      y_ext;
    logic [Y_W:0]      y_inc;
    logic [Y_W-1:0]    y_dec;
    logic [Y_W:0]      pad_l_ext;
    logic [Y_W:0]      pad_r_ext;
    logic              ovl_l;
    logic              ovl_r;
    logic              in_mouth;

    assign x_ext     = {1'b0, x_q};
    assign x_inc     = x_ext + X_SPD;
    assign x_dec     = x_q - X_SPD_N;
    assign y_ext     = {1'b0, y_q};
    assign y_inc     = y_ext + Y_SPD;
    assign y_dec     = y_q - Y_SPD_N;
    assign pad_l_ext = {1'b0, pad_l_y};
    assign pad_r_ext = {1'b0, pad_r_y};

    // Paddle and goal-mouth tests all use the current row, before this step's move.
    assign ovl_l    = (y_ext < (pad_l_ext + Y_PADH)) && (pad_l_ext < (y_ext + Y_PUCK));
    assign ovl_r    = (y_ext < (pad_r_ext + Y_PADH)) && (pad_r_ext < (y_ext + Y_PUCK));
    assign in_mouth = (y_ext >= Y_GLO) && ((y_ext + Y_PUCK) <= Y_GHI);

    // Vertical move: clamp at the top/bottom wall and reflect.
    always_comb begin
        y_d     = y_q;
        dir_y_d = dir_y_q;
        y_refl  = 1'b0;
        if (dir_y_q) begin
            if (y_inc >= Y_MAX) begin
                y_d     = Y_MAX_N;
                dir_y_d = 1'b0;
                y_refl  = 1'b1;
            end else begin
                y_d = y_inc[Y_W-1:0];
            end
        end else if (y_ext <= Y_SPD) begin
            y_d     = '0;
            dir_y_d = 1'b1;
            y_refl  = 1'b1;
        end else begin
            y_d = y_dec;
        end
    end

    // Horizontal move: paddles take priority over the side walls.
    always_comb begin
        x_d     = x_q;
        dir_x_d = dir_x_q;
        x_refl  = 1'b0;
        x_wall  = 1'b0;
        if (dir_x_q) begin
            if (ovl_r && ((x_ext + X_PUCK) <= X_PADR) && ((x_inc + X_PUCK) > X_PADR)) begin
                x_d     = X_PADR_HIT;
                dir_x_d = 1'b0;
                x_refl  = 1'b1;
            end else if (x_inc >= X_MAX) begin
                x_d     = X_MAX_N;
                dir_x_d = 1'b0;
                x_refl  = 1'b1;
                x_wall  = 1'b1;
            end else begin
                x_d = x_inc[X_W-1:0];
            end
        end else begin
            if (ovl_l && (x_ext >= X_PADL) && (x_ext < (X_PADL + X_SPD))) begin
                x_d     = X_PADL_N;
                dir_x_d = 1'b1;
                x_refl  = 1'b1;
            end else if (x_ext <= X_SPD) begin
                x_d     = '0;
                dir_x_d = 1'b1;
                x_refl  = 1'b1;
                x_wall  = 1'b1;
            end else begin
                x_d = x_dec;
            end
        end
    end

    // A side-wall contact inside the mouth is a goal rather than a reflection.
    assign goal_hit = GOALS_ON & x_wall & in_mouth;

    // Serve/score sequencer owning every registered output.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            x_q      <= X_CTR;
            y_q      <= Y_CTR;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            bounce_q <= 1'b0;
            goal_l_q <= 1'b0;
            goal_r_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            bounce_q <= 1'b0;
            goal_l_q <= 1'b0;
            goal_r_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (serve) begin
                        state_q <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (step) begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        dir_y_q <= dir_y_d;
                        if (goal_hit) begin
                            // Direction is kept so the exit knows which goal was scored.
                            goal_l_q <= ~dir_x_q;
                            goal_r_q <= dir_x_q;
                            bounce_q <= y_refl;
                            hold_q   <= HOLD_LAST;
                            state_q  <= ST_SCORED;
                        end else begin
                            dir_x_q  <= dir_x_d;
                            bounce_q <= x_refl | y_refl;
                        end
                    end
                end
                ST_SCORED: begin
                    if (step) begin
                        if (hold_q == '0) begin
                            state_q <= ST_IDLE;
                            x_q     <= X_CTR;
                            y_q     <= Y_CTR;
                            dir_y_q <= 1'b1;
                            dir_x_q <= ~dir_x_q;
                        end else begin
                            hold_q <= hold_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign dir_x  = dir_x_q;
    assign dir_y  = dir_y_q;
    assign bounce = bounce_q;
    assign goal_l = goal_l_q;
    assign goal_r = goal_r_q;
    assign state  = state_q;

endmodule

// File: tb/tb_puck_motion.sv
// Bench for puck_motion: integer reference model compared every cycle,
// directed trajectories with hand-computed values, then random play.
module tb_puck_motion;

    localparam int FW = 160, FH = 120, P = 4, S = 1, PH = 16;
    localparam int XL = 8, XR = 148, GL = 40, GH = 80, HOLD = 60;
`ifdef PUCK_GOALS_EN
    localparam bit GOALS = 1'b1;
`else
    localparam bit GOALS = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n, step, serve;
    logic [6:0] pad_l_y, pad_r_y;
    logic [7:0] x;
    logic [6:0] y;
    logic       dir_x, dir_y, bounce, goal_l, goal_r;
    logic [1:0] state;

    puck_motion dut (
        .clock(clock), .reset_n(reset_n), .step(step), .serve(serve),
        .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
        .x(x), .y(y), .dir_x(dir_x), .dir_y(dir_y), .bounce(bounce),
        .goal_l(goal_l), .goal_r(goal_r), .state(state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference state (0 idle, 1 play, 2 scored)
    int m_x, m_y, m_dx, m_dy, m_st, m_cnt, m_b, m_gl, m_gr;

    function automatic void model_reset();
        m_x = (FW - P) / 2; m_y = (FH - P) / 2;
        m_dx = 1; m_dy = 1; m_st = 0; m_cnt = 0;
        m_b = 0; m_gl = 0; m_gr = 0;
    endfunction

    function automatic void model_edge(bit rn, bit st, bit sv, int pl, int pr);
        int nx, ny, ndx, ndy;
        bit xb, yb, wall, goal, ol, orr;
        if (!rn) begin
            model_reset();
            return;
        end
        m_b = 0; m_gl = 0; m_gr = 0;
        if (m_st == 0) begin
            if (sv) m_st = 1;
        end else if (m_st == 1) begin
            if (st) begin
                xb = 0; yb = 0; wall = 0;
                ny = m_dy ? m_y + S : m_y - S;
                ndy = m_dy;
                if (ny >= FH - P) begin ny = FH - P; ndy = 0; yb = 1; end
                else if (ny <= 0) begin ny = 0; ndy = 1; yb = 1; end
                ol  = (m_y < pl + PH) && (pl < m_y + P);
                orr = (m_y < pr + PH) && (pr < m_y + P);
                nx = m_dx ? m_x + S : m_x - S;
                ndx = m_dx;
                if (m_dx == 1 && orr && m_x + P <= XR && nx + P > XR) begin
                    nx = XR - P; ndx = 0; xb = 1;
                end else if (m_dx == 0 && ol && m_x >= XL && nx < XL) begin
                    nx = XL; ndx = 1; xb = 1;
                end else if (nx >= FW - P) begin
                    nx = FW - P; ndx = 0; wall = 1;
                end else if (nx <= 0) begin
                    nx = 0; ndx = 1; wall = 1;
                end
                goal = GOALS && wall && m_y >= GL && m_y + P <= GH;
                m_x = nx; m_y = ny; m_dy = ndy;
                if (goal) begin
                    m_gl = (nx == 0);
                    m_gr = (nx != 0);
                    m_b = yb;
                    m_st = 2;
                    m_cnt = 0;
                end else begin
                    m_dx = ndx;
                    m_b = xb | yb | wall;
                end
            end
        end else begin
            if (st) begin
                m_cnt++;
                if (m_cnt == HOLD) begin
                    m_st = 0;
                    m_dx = (m_x == 0) ? 1 : 0;
                    m_x = (FW - P) / 2; m_y = (FH - P) / 2; m_dy = 1;
                end
            end
        end
    endfunction

    task automatic compare();
        checks++;
        if (int'(x) != m_x || int'(y) != m_y || int'(dir_x) != m_dx || int'(dir_y) != m_dy ||
            int'(bounce) != m_b || int'(goal_l) != m_gl || int'(goal_r) != m_gr ||
            int'(state) != m_st) begin
            errors++;
            $display("FAIL model cycle %0d: dut x=%0d y=%0d dx=%0d dy=%0d b=%0d gl=%0d gr=%0d st=%0d, expected x=%0d y=%0d dx=%0d dy=%0d b=%0d gl=%0d gr=%0d st=%0d",
                     cyc, x, y, dir_x, dir_y, bounce, goal_l, goal_r, state,
                     m_x, m_y, m_dx, m_dy, m_b, m_gl, m_gr, m_st);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input bit rn, input bit st, input bit sv);
        reset_n = rn; step = st; serve = sv;
        @(posedge clock);
        model_edge(rn, st, sv, int'(pad_l_y), int'(pad_r_y));
        #1;
        cyc++;
        compare();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        lit({tag, "_x"}, int'(x), 78);
        lit({tag, "_y"}, int'(y), 58);
        lit({tag, "_dx"}, int'(dir_x), 1);
        lit({tag, "_dy"}, int'(dir_y), 1);
        lit({tag, "_state"}, int'(state), 0);
        lit({tag, "_pulses"}, int'({bounce, goal_l, goal_r}), 0);
    endtask

    initial begin
        int pv;
        model_reset();
        pad_l_y = '0; pad_r_y = '0;
        reset_n = 1'b0; step = 1'b0; serve = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check_reset_vals("reset");

        tick(1'b1, 1'b1, 1'b0);
        lit("idle_step_ignored", int'(x), 78);
        tick(1'b1, 1'b1, 1'b1);
        lit("serve_state", int'(state), 1);
        lit("serve_no_move", int'(x), 78);

        for (int k = 1; k <= 3; k++) begin
            tick(1'b1, 1'b1, 1'b0);
            lit("first_x", int'(x), 78 + k);
            lit("first_y", int'(y), 58 + k);
            lit("first_bounce", int'(bounce), 0);
        end

        steps(54);
        lit("pre_wall_y", int'(y), 115);
        steps(1);
        lit("ywall_y", int'(y), 116);
        lit("ywall_dy", int'(dir_y), 0);
        lit("ywall_bounce", int'(bounce), 1);
        tick(1'b1, 1'b0, 1'b0);
        lit("ywall_pulse_len", int'(bounce), 0);
        steps(1);
        lit("ywall_back_y", int'(y), 115);

        steps(7);
        lit("pre_pad_x", int'(x), 144);
        lit("pre_pad_y", int'(y), 108);
        pad_r_y = 7'd100;
        steps(1);
        lit("rpad_x", int'(x), 144);
        lit("rpad_dx", int'(dir_x), 0);
        lit("rpad_bounce", int'(bounce), 1);
        pad_r_y = '0;

        tick(1'b0, 1'b0, 1'b0);
        check_reset_vals("reset_play");

        tick(1'b1, 1'b0, 1'b1);
        steps(66);
        steps(1);
        lit("rpad_miss_x", int'(x), 145);
        lit("rpad_miss_bounce", int'(bounce), 0);
        steps(166);
        lit("pre_goal_x", int'(x), 1);
        lit("pre_goal_y", int'(y), 59);
        steps(1);
        lit("lwall_x", int'(x), 0);
        lit("lwall_y", int'(y), 60);
`ifdef PUCK_GOALS_EN
        lit("goal_l", int'(goal_l), 1);
        lit("goal_bounce", int'(bounce), 0);
        lit("goal_state", int'(state), 2);
        lit("goal_dx", int'(dir_x), 0);
        for (int i = 0; i < HOLD - 1; i++) tick(1'b1, 1'b1, 1'b1);
        lit("hold_state", int'(state), 2);
        lit("hold_x", int'(x), 0);
        steps(1);
        check_reset_vals("hold_exit");
        tick(1'b1, 1'b0, 1'b1);
        steps(234);
        lit("goal2_state", int'(state), 2);
        steps(5);
        tick(1'b0, 1'b0, 1'b0);
        check_reset_vals("reset_scored");
`else
        lit("lwall_dx", int'(dir_x), 1);
        lit("lwall_bounce", int'(bounce), 1);
        lit("lwall_goal", int'(goal_l), 0);
        lit("lwall_state", int'(state), 1);
`endif

        for (int i = 0; i < 20000; i++) begin
            bit rn, st, sv;
            rn = ($urandom_range(0, 1499) != 0);
            st = ($urandom_range(0, 9) < 7);
            sv = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 11) == 0) begin
                pv = m_y - int'($urandom_range(0, 22));
                if ($urandom_range(0, 3) == 0) pv = int'($urandom_range(0, 127));
                if (pv < 0) pv = 0;
                if (pv > 127) pv = 127;
                if ($urandom_range(0, 1) == 0) pad_l_y = 7'(pv);
                else pad_r_y = 7'(pv);
            end
            tick(rn, st, sv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
